// File: rtl/fifo_n_base_if.sv
// Method-level handshake bundle for fifo_n_base: enq/deq/first/clear methods
// plus occupancy status. The producer/consumer side uses master, the FIFO uses slave.
interface fifo_n_base_if #(
  parameter int unsigned width = 32,
  parameter int unsigned depth = 4
);
  localparam int unsigned cw = $clog2(depth + 1);

  logic             in_enq__ENA;
  logic [width-1:0] in_enq_v;
  logic             in_enq__RDY;
  logic             out_deq__ENA;
  logic             out_deq__RDY;
  logic [width-1:0] out_first;
  logic             out_first__RDY;
  logic             clear__ENA;
  logic             clear__RDY;
  logic [cw-1:0]    count;
  logic             almost_full;
  logic             almost_empty;

  modport master (
    output in_enq__ENA, in_enq_v, out_deq__ENA, clear__ENA,
    input  in_enq__RDY, out_deq__RDY, out_first, out_first__RDY,
           clear__RDY, count, almost_full, almost_empty
  );

  modport slave (
    input  in_enq__ENA, in_enq_v, out_deq__ENA, clear__ENA,
    output in_enq__RDY, out_deq__RDY, out_first, out_first__RDY,
           clear__RDY, count, almost_full, almost_empty
  );
endinterface

// File: rtl/fifo_n_base.sv
// DEPTH-entry circular buffer with enq/deq/first/clear methods, occupancy count
// and almost-full/almost-empty flags. All ready signals depend only on the count
// register, so there is no combinational path from any ENA to any RDY.
module fifo_n_base #(
  parameter int unsigned width      = 32,
  parameter int unsigned depth      = 4,
  parameter int unsigned afull_lvl  = 3,
  parameter int unsigned aempty_lvl = 1
) (
  input logic          CLK,
  input logic          nRST,
  fifo_n_base_if.slave bus
);
  localparam int unsigned cw = $clog2(depth + 1);
  localparam int unsigned pw = $clog2(depth);

  localparam logic [cw-1:0] full_cnt   = cw'(depth);
  localparam logic [cw-1:0] afull_cnt  = cw'(afull_lvl);
  localparam logic [cw-1:0] aempty_cnt = cw'(aempty_lvl);
  localparam logic [pw-1:0] last_ptr   = pw'(depth - 1);

  logic [width-1:0] storage [depth];
  logic [pw-1:0]    wr_ptr;
  logic [pw-1:0]    rd_ptr;
  logic [cw-1:0]    count;
  logic             not_full;
  logic             not_empty;
  logic             do_enq;
  logic             do_deq;
  logic [pw-1:0]    wr_next;
  logic [pw-1:0]    rd_next;

  // Handshake qualification and pointer advance (explicit wrap for any depth)
  always_comb begin
    not_full  = (count != full_cnt);
    not_empty = (count != '0);
    do_enq    = bus.in_enq__ENA && not_full;
    do_deq    = bus.out_deq__ENA && not_empty;
    wr_next   = (wr_ptr == last_ptr) ? '0 : wr_ptr + 1'b1;
    rd_next   = (rd_ptr == last_ptr) ? '0 : rd_ptr + 1'b1;
  end

  // Storage, pointers and occupancy; clear wins over enq/deq and leaves data intact
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      storage <= '{default: '0};
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else if (bus.clear__ENA) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) begin
        storage[wr_ptr] <= bus.in_enq_v;
        wr_ptr          <= wr_next;
      end
      if (do_deq) begin
        rd_ptr <= rd_next;
      end
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Status outputs, all derived from registered state
  always_comb begin
    bus.in_enq__RDY    = not_full;
    bus.out_deq__RDY   = not_empty;
    bus.out_first__RDY = not_empty;
    bus.out_first      = storage[rd_ptr];
    bus.clear__RDY     = 1'b1;
    bus.count          = count;
    bus.almost_full    = (count >= afull_cnt);
    bus.almost_empty   = (count <= aempty_cnt);
  end
endmodule
